// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer.
// Fetch side: zero-latency combinational lookup on pc.
// Execute side: one registered write port that trains the 2-bit direction
// counters, refreshes targets and allocates entries for taken branches.
module branch_target_buffer #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        btb_pc_valid,
  output logic        btb_pc_predictTaken,
  output logic [31:0] btb_target_pc,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        invalidate_all
);

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CTR_MIN        = 2'b00;
  localparam logic [1:0] CTR_MAX        = 2'b11;
  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

  // ---------------------------------------------------------------------------
  // Storage. valid/lru carry the architectural state; tag/target/ctr are only
  // meaningful where the matching valid bit is set.
  // ---------------------------------------------------------------------------
  logic [SETS-1:0]  valid_q  [2];
  logic [SETS-1:0]  lru_q;                 // 0: way0 is least recently used
  logic [TAG_W-1:0] tag_q    [2][SETS];
  logic [31:0]      target_q [2][SETS];
  logic [1:0]       ctr_q    [2][SETS];

  // pc[1:0] and update_pc[1:0] carry no information for the lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc[1:0], update_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Fetch-side lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_set;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit0;
  logic             lk_hit1;

  assign lk_set  = pc[IDX_W+1:2];
  assign lk_tag  = pc[31:IDX_W+2];
  assign lk_hit0 = valid_q[0][lk_set] && (tag_q[0][lk_set] == lk_tag);
  assign lk_hit1 = valid_q[1][lk_set] && (tag_q[1][lk_set] == lk_tag);

  // Select the hitting way (way0 wins a double hit); force zeros on a miss so
  // unreset payload never reaches next-PC selection.
  always_comb begin
    // NOTE: every output gets a default before the branches, so no latch is inferred.
    btb_pc_valid        = 1'b0;
    btb_pc_predictTaken = 1'b0;
    btb_target_pc       = 32'h0;
    if (lk_hit0) begin
      btb_pc_valid        = 1'b1;
      btb_pc_predictTaken = ctr_q[0][lk_set][1];
      btb_target_pc       = target_q[0][lk_set];
    end else if (lk_hit1) begin
      btb_pc_valid        = 1'b1;
      btb_pc_predictTaken = ctr_q[1][lk_set][1];
      btb_target_pc       = target_q[1][lk_set];
    end
  end

  // ---------------------------------------------------------------------------
  // Execute-side update decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] upd_set;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit0;
  logic             upd_hit1;
  logic             upd_hit;
  logic             hit_way;
  logic             victim_way;
  logic             wr_en;
  logic             wr_way;
  logic             wr_alloc;
  logic             wr_target;
  logic [1:0]       cur_ctr;
  logic [1:0]       ctr_nxt;

  assign upd_set  = update_pc[IDX_W+1:2];
  assign upd_tag  = update_pc[31:IDX_W+2];
  assign upd_hit0 = valid_q[0][upd_set] && (tag_q[0][upd_set] == upd_tag);
  assign upd_hit1 = valid_q[1][upd_set] && (tag_q[1][upd_set] == upd_tag);
  assign upd_hit  = upd_hit0 || upd_hit1;
  assign hit_way  = !upd_hit0;

  // Victim: first invalid way (way0 preferred), otherwise the LRU way.
  always_comb begin
    victim_way = lru_q[upd_set];
    if (!valid_q[0][upd_set]) begin
      victim_way = 1'b0;
    end else if (!valid_q[1][upd_set]) begin
      victim_way = 1'b1;
    end
  end

  // A write happens on any hit, or on a taken miss (allocation); invalidate
  // takes priority and drops the update entirely.
  assign wr_en     = update_en && !invalidate_all && (upd_hit || update_taken);
  assign wr_alloc  = !upd_hit;
  assign wr_way    = upd_hit ? hit_way : victim_way;
  assign wr_target = wr_alloc || update_taken;
  assign cur_ctr   = ctr_q[hit_way][upd_set];

  // Saturating counter training on a hit; fresh entries start weakly taken.
  always_comb begin
    ctr_nxt = CTR_WEAK_TAKEN;
    if (upd_hit) begin
      if (update_taken) begin
        ctr_nxt = (cur_ctr == CTR_MAX) ? CTR_MAX : cur_ctr + 2'd1;
      end else begin
        ctr_nxt = (cur_ctr == CTR_MIN) ? CTR_MIN : cur_ctr - 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural state: valid and LRU bits, async reset, sync invalidate.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else if (invalidate_all) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else if (wr_en) begin
      valid_q[wr_way][upd_set] <= 1'b1;
      lru_q[upd_set]           <= ~wr_way;
    end
  end

  // Payload arrays: single write port, one way per cycle.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is deliberately not reset; the valid bits gate every read of it.
    if (wr_en) begin
      ctr_q[wr_way][upd_set] <= ctr_nxt;
      if (wr_target) begin
        target_q[wr_way][upd_set] <= update_target;
      end
      if (wr_alloc) begin
        tag_q[wr_way][upd_set] <= upd_tag;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer. Stimulus pushes expected lookup
// results into a scoreboard queue; a monitor pops and compares on each
// falling clock edge.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        btb_pc_valid;
  logic        btb_pc_predictTaken;
  logic [31:0] btb_target_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        invalidate_all;

  typedef struct packed {
    logic        v;
    logic        t;
    logic [31:0] tgt;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    n_checks = 0;
  int    n_pass   = 0;

  branch_target_buffer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pc                  (pc),
    .btb_pc_valid        (btb_pc_valid),
    .btb_pc_predictTaken (btb_pc_predictTaken),
    .btb_target_pc       (btb_target_pc),
    .update_en           (update_en),
    .update_pc           (update_pc),
    .update_target       (update_target),
    .update_taken        (update_taken),
    .invalidate_all      (invalidate_all)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare the DUT lookup outputs against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, e);
      end
    end
  end

  task automatic check(input string nm, input exp_t e);
    n_checks++;
    if (btb_pc_valid === e.v && btb_pc_predictTaken === e.t && btb_target_pc === e.tgt) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got valid=%0b taken=%0b target=%h, expected valid=%0b taken=%0b target=%h",
               nm, btb_pc_valid, btb_pc_predictTaken, btb_target_pc, e.v, e.t, e.tgt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic v, input logic t, input logic [31:0] tgt);
    exp_t e;
    e.v   = v;
    e.t   = t;
    e.tgt = tgt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Present a lookup for one cycle and queue its expected result.
  task automatic look(input string nm, input logic [31:0] a, input logic v, input logic t,
                      input logic [31:0] tgt);
    pc = a;
    expect_out(nm, v, t, tgt);
    step();
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] tgt, input logic taken);
    update_en     = 1'b1;
    update_pc     = a;
    update_target = tgt;
    update_taken  = taken;
    step();
    update_en     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n          = 1'b0;
    pc             = 32'h0;
    update_en      = 1'b0;
    update_pc      = 32'h0;
    update_target  = 32'h0;
    update_taken   = 1'b0;
    invalidate_all = 1'b0;
    do_reset();

    // Reset state
    look("reset_100", 32'h100, 1'b0, 1'b0, 32'h0);
    look("reset_000", 32'h000, 1'b0, 1'b0, 32'h0);

    // Allocation; the same-cycle lookup still sees the old contents
    update_en     = 1'b1;
    update_pc     = 32'h100;
    update_target = 32'h200;
    update_taken  = 1'b1;
    look("alloc_same_cycle", 32'h100, 1'b0, 1'b0, 32'h0);
    update_en     = 1'b0;
    look("alloc_next_cycle", 32'h100, 1'b1, 1'b1, 32'h200);
    look("alloc_low_bits",   32'h103, 1'b1, 1'b1, 32'h200);
    look("other_set_miss",   32'h104, 1'b0, 1'b0, 32'h0);
    look("same_set_oth_tag", 32'h140, 1'b0, 1'b0, 32'h0);

    // Counter training: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
    upd(32'h100, 32'hDEAD_0000, 1'b0);
    look("ctr_01", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 32'hDEAD_0000, 1'b0);
    look("ctr_00", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 32'hDEAD_0000, 1'b0);
    look("ctr_00_sat", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 32'h200, 1'b1);
    look("ctr_up_01", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 32'h200, 1'b1);
    look("ctr_up_10", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h200, 1'b1);
    look("ctr_up_11", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h300, 1'b1);
    look("ctr_11_sat_tgt", 32'h100, 1'b1, 1'b1, 32'h300);
    upd(32'h100, 32'hDEAD_0000, 1'b0);
    look("ctr_11_to_10", 32'h100, 1'b1, 1'b1, 32'h300);

    // Conflict in set 0: third allocation evicts the LRU way (way0)
    do_reset();
    upd(32'h000, 32'hA00, 1'b1);
    upd(32'h040, 32'hA40, 1'b1);
    upd(32'h080, 32'hA80, 1'b1);
    look("conf_040_hit",  32'h040, 1'b1, 1'b1, 32'hA40);
    look("conf_080_hit",  32'h080, 1'b1, 1'b1, 32'hA80);
    look("conf_000_miss", 32'h000, 1'b0, 1'b0, 32'h0);

    // Not-taken hit on way0 moves LRU to way1; next allocation evicts 0x040
    upd(32'h080, 32'hDEAD_0000, 1'b0);
    upd(32'h0C0, 32'hAC0, 1'b1);
    look("lru_080_kept",  32'h080, 1'b1, 1'b0, 32'hA80);
    look("lru_0c0_hit",   32'h0C0, 1'b1, 1'b1, 32'hAC0);
    look("lru_040_evict", 32'h040, 1'b0, 1'b0, 32'h0);

    // Not-taken miss allocates nothing and evicts nothing
    upd(32'h500, 32'h600, 1'b0);
    look("nt_miss_500",  32'h500, 1'b0, 1'b0, 32'h0);
    look("nt_keep_080",  32'h080, 1'b1, 1'b0, 32'hA80);
    look("nt_keep_0c0",  32'h0C0, 1'b1, 1'b1, 32'hAC0);

    // Independent set
    upd(32'h104, 32'h900, 1'b1);
    look("set1_hit", 32'h104, 1'b1, 1'b1, 32'h900);

    // invalidate_all wins over a simultaneous update
    invalidate_all = 1'b1;
    upd(32'h200, 32'hB00, 1'b1);
    invalidate_all = 1'b0;
    look("inv_080_miss", 32'h080, 1'b0, 1'b0, 32'h0);
    look("inv_0c0_miss", 32'h0C0, 1'b0, 1'b0, 32'h0);
    look("inv_104_miss", 32'h104, 1'b0, 1'b0, 32'h0);
    look("inv_200_miss", 32'h200, 1'b0, 1'b0, 32'h0);
    upd(32'h200, 32'hB00, 1'b1);
    look("post_inv_alloc", 32'h200, 1'b1, 1'b1, 32'hB00);

    // Asynchronous reset between clock edges drops outputs immediately
    pc = 32'h200;
    expect_out("async_rst", 1'b0, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    look("after_rst_miss", 32'h200, 1'b0, 1'b0, 32'h0);

    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
